pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the ARM core, the generic successor to the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data payload between stages using a valid/ready handshake.
- Supports a synchronous flush and an optional 2-entry skid buffer, which breaks the combinational ready path.
- Forces all control bits to zero whenever no valid entry is presented, so bubbles never assert write or memory enables downstream.
- Includes a saturating stall counter for performance debug.

Parameters:
- CTRL_W, 8, width of the control field (WB_EN, MEM_R/W_EN, B, S, EXE_CMD, ...); forced to zero on bubble or flush.
- DATA_W, 128, width of the payload (PC, operands, immediates, dest, SR).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with pass-through ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held entries (branch taken / hazard).
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream accepts this cycle (the successor to the old ready/freeze input).
- out_ctrl  out  CTRL_W  control bits; zero when out_valid=0.
- out_data  out  DATA_W  payload; zero after reset or flush until the next load.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
Clock and reset
- One clock, clk. Reset rst is synchronous and active-high.
- During rst: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid entry cleared, stall_cnt=0.
- in_ready=1 on the cycle after reset releases.

Handshake rules
- Upstream transfer occurs when in_valid && in_ready.
- Downstream transfer occurs when out_valid && out_ready.
- Latency from accept to out_valid is 1 cycle. Ordering is strictly FIFO.
- out_ctrl/out_data are register outputs; there is no combinational path from the in_* ports to the out_* ports.

States for SKID=1 (main register plus skid register)
- EMPTY
  - out_valid=0, in_ready=1.
  - in_valid: main<=in, go to FULL.
- FULL
  - out_valid=1, in_ready=1.
  - in_valid && out_ready: main<=in, stay in FULL.
  - !in_valid && out_ready: go to EMPTY.
  - in_valid && !out_ready: skid<=in, go to SKIDF.
  - Otherwise hold.
- SKIDF
  - out_valid=1, in_ready=0.
  - out_ready: main<=skid, go to FULL.
  - Otherwise hold.
- in_ready is decoded from the state register only; no combinational path from out_ready.

SKID=0
- Only the EMPTY and FULL states exist.
- in_ready = !out_valid || out_ready (combinational).
- In FULL with in_valid && !out_ready, no transfer occurs and the entry is held.

Flush
- flush=1 goes to EMPTY next cycle.
- Clears out_valid, out_ctrl, out_data and the skid entry.
- Overrides any simultaneous accept or drain.
- in_ready during a flush cycle follows the current state, but any entry accepted that cycle is discarded.
- rst has priority over flush.

Bubble rule
- out_ctrl = 0 whenever out_valid = 0, including after drain to EMPTY.
- out_data may hold its last value after a normal drain; it is zeroed only by rst or flush.

Stall counter
- stall_cnt increments by 1 each cycle out_valid && !out_ready.
- Saturates at 2^CNT_W-1 with no wrap.
- Cleared only by rst; flush does not clear it.

Stable-output rules
- While out_valid && !out_ready, out_ctrl/out_data must not change (verification assertion).
- In EMPTY with in_valid=0, out_ctrl and out_valid stay 0.

Test Plan:
1. Reset: hold rst 2 cycles with in_valid=1, in_ctrl=0xFF -> out_valid=0, out_ctrl=0x00, out_data=0, stall_cnt=0; in_ready=1 the cycle after release.
2. Streaming, SKID=1, out_ready=1: push ctrl 0x01, 0x02, 0x03 on consecutive cycles -> out_ctrl 0x01, 0x02, 0x03 on the following cycles, out_valid continuously 1, in_ready continuously 1.
3. Backpressure, SKID=1: out_ready=0 while pushing A=0x11, B=0x22, C=0x33 -> A in main and B in skid; in_ready=0 in the cycle after B is accepted; C is held upstream; stall_cnt counts each stalled cycle. Release out_ready -> A, B, C output in order, with no loss or duplication.
4. Flush while in SKIDF with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, out_data=0, state EMPTY; the entry presented with flush is not output; stall_cnt retains its value.
5. SKID=0 in FULL, out_ready=0, in_valid=1 -> in_ready=0 in the same cycle and out_data unchanged. Then out_ready=1 -> new entry loaded the next cycle.
6. Saturation with CNT_W=4: stall for 20 cycles -> stall_cnt reaches 15 and stays at 15. Then assert rst -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid entry and stall counter
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_SKIDF = 2'b10;

    logic [1:0]        state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign out_valid = (state != ST_EMPTY);
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    // With the skid entry, ready comes only from the state register.
    assign in_ready = (SKID != 0) ? (state != ST_SKIDF)
                                  : ((state == ST_EMPTY) || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                        state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            main_ctrl <= in_ctrl;
                            main_data <= in_data;
                        end else begin
                            // Drained: ctrl drops to a bubble, data keeps its last value.
                            main_ctrl <= '0;
                            state     <= ST_EMPTY;
                        end
                    end else if (in_valid && (SKID != 0)) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                        state     <= ST_SKIDF;
                    end
                end
                ST_SKIDF: begin
                    if (out_ready) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        state     <= ST_FULL;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    main_ctrl <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a FIFO reference model
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, out_ready;
    logic [7:0]   in_ctrl;
    logic [127:0] in_data;

    logic         ir0, ov0, ir1, ov1, ir2, ov2;
    logic [7:0]   oc0, oc1, oc2;
    logic [127:0] od0, od1, od2;
    logic [15:0]  sc0, sc1;
    logic [3:0]   sc2;

    int vectors = 0;
    int miscompares = 0;

    // Instance 0: SKID=1, instance 1: SKID=0, instance 2: SKID=1 with 4-bit counter.
    logic [7:0]   m_ctrl [3][2];
    logic [127:0] m_data [3][2];
    int           m_n    [3];
    logic         m_zero [3];
    int           m_cnt  [3];
    bit           known = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
        .out_ctrl(oc0), .out_data(od0), .stall_cnt(sc0));

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(0), .CNT_W(16)) dut_noskid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
        .out_ctrl(oc1), .out_data(od1), .stall_cnt(sc1));

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov2), .out_ready(out_ready),
        .out_ctrl(oc2), .out_data(od2), .stall_cnt(sc2));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input int k);
        if (k == 1) return (m_n[k] == 0) || out_ready;
        return m_n[k] < 2;
    endfunction

    task automatic check_inst(input int k, input logic ov, input logic ir,
                              input logic [7:0] oc, input logic [127:0] od, input logic [15:0] sc);
        chk($sformatf("i%0d_out_valid", k), {127'd0, ov}, {127'd0, m_n[k] > 0});
        chk($sformatf("i%0d_in_ready", k), {127'd0, ir}, {127'd0, model_ready(k)});
        chk($sformatf("i%0d_out_ctrl", k), {120'd0, oc}, (m_n[k] > 0) ? {120'd0, m_ctrl[k][0]} : 128'd0);
        if (m_n[k] > 0)
            chk($sformatf("i%0d_out_data", k), od, m_data[k][0]);
        else if (m_zero[k])
            chk($sformatf("i%0d_out_data_zero", k), od, 128'd0);
        chk($sformatf("i%0d_stall_cnt", k), {112'd0, sc}, 128'(m_cnt[k]));
    endtask

    task automatic model_step(input int k);
        int  cmax;
        bit  pop, push;
        cmax = (k == 2) ? 15 : 65535;
        if (rst) begin
            m_n[k] = 0; m_zero[k] = 1'b1; m_cnt[k] = 0;
            return;
        end
        if (m_n[k] > 0 && !out_ready && m_cnt[k] < cmax) m_cnt[k]++;
        if (flush) begin
            m_n[k] = 0; m_zero[k] = 1'b1;
            return;
        end
        pop  = (m_n[k] > 0) && out_ready;
        push = in_valid && model_ready(k);
        if (pop) begin
            m_ctrl[k][0] = m_ctrl[k][1];
            m_data[k][0] = m_data[k][1];
            m_n[k]--;
            m_zero[k] = 1'b0;
        end
        if (push) begin
            m_ctrl[k][m_n[k]] = in_ctrl;
            m_data[k][m_n[k]] = in_data;
            m_n[k]++;
            m_zero[k] = 1'b0;
        end
    endtask

    task automatic tick();
        bit was_rst;
        @(negedge clk);
        if (known) begin
            check_inst(0, ov0, ir0, oc0, od0, sc0);
            check_inst(1, ov1, ir1, oc1, od1, sc1);
            check_inst(2, ov2, ir2, oc2, od2, {12'd0, sc2});
        end
        for (int k = 0; k < 3; k++) model_step(k);
        was_rst = rst;
        @(posedge clk);
        #1;
        if (was_rst) known = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic r);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        out_ready = r;
    endtask

    logic [127:0] held;

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b1, 8'hFF, 1'b0);
        #1;

        // Reset with a valid entry presented upstream
        tick(); tick();
        chk("rst_out_valid", {127'd0, ov0}, 128'd0);
        chk("rst_out_ctrl", {120'd0, oc0}, 128'd0);
        chk("rst_out_data", od0, 128'd0);
        chk("rst_stall_cnt", {112'd0, sc0}, 128'd0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        #1;
        chk("rst_release_in_ready", {127'd0, ir0}, 128'd1);

        // Streaming with out_ready held high
        drive(1'b1, 8'h01, 1'b1); tick();
        chk("stream_0x01", {120'd0, oc0}, 128'h01);
        drive(1'b1, 8'h02, 1'b1); tick();
        chk("stream_0x02", {120'd0, oc0}, 128'h02);
        drive(1'b1, 8'h03, 1'b1); tick();
        chk("stream_0x03", {120'd0, oc0}, 128'h03);
        drive(1'b0, 8'h00, 1'b1); tick();
        chk("stream_drain_ctrl", {120'd0, oc0}, 128'h00);

        // Backpressure fills main then skid; third entry waits upstream
        drive(1'b1, 8'h11, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0); tick();
        chk("bp_in_ready_skidf", {127'd0, ir0}, 128'd0);
        drive(1'b1, 8'h33, 1'b0); tick(); tick();
        chk("bp_main_holds_a", {120'd0, oc0}, 128'h11);
        out_ready = 1'b1; tick();
        chk("bp_release_b", {120'd0, oc0}, 128'h22);
        tick();
        chk("bp_release_c", {120'd0, oc0}, 128'h33);
        drive(1'b0, 8'h00, 1'b1); tick(); tick();

        // Flush while the skid entry is occupied
        drive(1'b1, 8'h55, 1'b0); tick();
        drive(1'b1, 8'h66, 1'b0); tick();
        flush = 1'b1;
        drive(1'b1, 8'h44, 1'b0); tick();
        flush = 1'b0;
        chk("flush_out_valid", {127'd0, ov0}, 128'd0);
        chk("flush_out_ctrl", {120'd0, oc0}, 128'd0);
        chk("flush_out_data", od0, 128'd0);
        chk("flush_stall_kept", {112'd0, sc0}, 128'(m_cnt[0]));
        drive(1'b0, 8'h00, 1'b1); tick(); tick();

        // Single-entry variant: held entry blocks a new one until out_ready
        drive(1'b1, 8'h77, 1'b0); tick();
        held = m_data[1][0];
        drive(1'b1, 8'h88, 1'b0);
        #1;
        chk("noskid_in_ready_low", {127'd0, ir1}, 128'd0);
        tick();
        chk("noskid_data_held", od1, held);
        out_ready = 1'b1;
        #1;
        chk("noskid_in_ready_high", {127'd0, ir1}, 128'd1);
        tick();
        chk("noskid_new_ctrl", {120'd0, oc1}, 128'h88);
        drive(1'b0, 8'h00, 1'b1); tick(); tick();

        // Stall counter saturation on the 4-bit instance
        rst = 1'b1; tick(); rst = 1'b0;
        drive(1'b1, 8'h99, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall_15", {124'd0, sc2}, 128'd15);
        tick();
        chk("sat_stall_stays_15", {124'd0, sc2}, 128'd15);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("sat_rst_clears", {124'd0, sc2}, 128'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 65);
            flush = ($urandom_range(0, 99) < 4);
            rst   = ($urandom_range(0, 199) < 1);
            tick();
        end
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
